// File: rtl/stopwatch_bcd_if.sv
// Button-pulse commands in, packed-BCD display value and status flags out.
// master drives the pulses (button controllers); slave is the stopwatch.
interface stopwatch_bcd_if;
    logic        btn_start_stop;
    logic        btn_lap;
    logic        btn_clear;
    logic [15:0] fnd_value;
    logic        running;
    logic        lap_active;
    logic        wrap;

    modport master (
        output btn_start_stop, btn_lap, btn_clear,
        input  fnd_value, running, lap_active, wrap
    );

    modport slave (
        input  btn_start_stop, btn_lap, btn_clear,
        output fnd_value, running, lap_active, wrap
    );
endinterface

// File: rtl/stopwatch_bcd.sv
// Centisecond stopwatch SS.cc (00.00-59.99) with run/pause/idle control and lap freeze.
// 1-cycle latency from pulse to outputs; no backpressure, pulses are acted on the cycle they arrive.
module stopwatch_bcd #(
    parameter int TICK_DIV = 1_000_000
) (
    input  logic         clk,
    input  logic         reset_n,
    stopwatch_bcd_if.slave bus
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_presc;
    logic [15:0]     r_dig;
    logic [15:0]     r_lap;
    logic            r_lap_active;
    logic            r_wrap;

    logic            w_tick;
    logic            w_clr;
    logic            w_lap_capture;
    logic            w_lap_release;
    logic [15:0]     w_dig_inc;
    logic            w_roll;

    assign w_tick = (r_state == S_RUN) && (r_presc == PMAX);

    // Priority clear > start_stop > lap; clear only bites outside RUN.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr         = 1'b0;
        w_lap_capture = 1'b0;
        w_lap_release = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.btn_clear)
                    w_clr = 1'b1;
                else if (bus.btn_start_stop)
                    w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (bus.btn_start_stop)
                    w_state_nxt = S_PAUSE;
                else if (bus.btn_lap) begin
                    if (r_lap_active)
                        w_lap_release = 1'b1;
                    else
                        w_lap_capture = 1'b1;
                end
            end
            S_PAUSE: begin
                if (bus.btn_clear) begin
                    w_state_nxt = S_IDLE;
                    w_clr       = 1'b1;
                end else if (bus.btn_start_stop)
                    w_state_nxt = S_RUN;
                else if (bus.btn_lap && r_lap_active)
                    w_lap_release = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_dig_inc = r_dig;
        w_roll    = 1'b0;
        if (r_dig[3:0] != 4'd9)
            w_dig_inc[3:0] = r_dig[3:0] + 4'd1;
        else begin
            w_dig_inc[3:0] = 4'd0;
            if (r_dig[7:4] != 4'd9)
                w_dig_inc[7:4] = r_dig[7:4] + 4'd1;
            else begin
                w_dig_inc[7:4] = 4'd0;
                if (r_dig[11:8] != 4'd9)
                    w_dig_inc[11:8] = r_dig[11:8] + 4'd1;
                else begin
                    w_dig_inc[11:8] = 4'd0;
                    if (r_dig[15:12] != 4'd5)
                        w_dig_inc[15:12] = r_dig[15:12] + 4'd1;
                    else begin
                        w_dig_inc[15:12] = 4'd0;
                        w_roll           = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_presc      <= '0;
            r_dig        <= '0;
            r_lap        <= '0;
            r_lap_active <= 1'b0;
            r_wrap       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wrap  <= w_tick && w_roll;
            if (w_clr) begin
                r_presc      <= '0;
                r_dig        <= '0;
                r_lap_active <= 1'b0;
            end else begin
                // Prescaler holds outside RUN so a paused partial tick resumes where it left off.
                if (r_state == S_RUN)
                    r_presc <= w_tick ? '0 : r_presc + 1'b1;
                if (w_tick)
                    r_dig <= w_dig_inc;
                if (w_lap_capture) begin
                    r_lap        <= r_dig;
                    r_lap_active <= 1'b1;
                end else if (w_lap_release)
                    r_lap_active <= 1'b0;
            end
        end
    end

    assign bus.fnd_value  = r_lap_active ? r_lap : r_dig;
    assign bus.running    = (r_state == S_RUN);
    assign bus.lap_active = r_lap_active;
    assign bus.wrap       = r_wrap;
endmodule

// File: tb/tb_stopwatch_bcd.sv
// Scoreboarded bench for stopwatch_bcd: a time-in-centiseconds model predicts every cycle,
// a negedge monitor compares DUT outputs against the queued predictions.
module tb_stopwatch_bcd;
    localparam int TD = 4;

    typedef struct packed {
        logic [15:0] fnd;
        logic        run;
        logic        lapa;
        logic        wrap;
    } exp_t;

    logic clk;
    logic reset_n;
    stopwatch_bcd_if bus();

    stopwatch_bcd #(.TICK_DIV(TD)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    bit   mon_en = 1'b1;

    // Reference model: elapsed centiseconds as a plain integer.
    bit m_run, m_idle, m_lapact;
    int m_phase, m_cs, m_lapcs;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic model_reset();
        m_run = 0; m_idle = 1; m_lapact = 0;
        m_phase = 0; m_cs = 0; m_lapcs = 0;
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit s, input bit l, input bit c);
        bit   tick, wr, run_old, idle_old;
        int   cs_old;
        exp_t e;
        tick     = m_run && (m_phase == TD - 1);
        wr       = tick && (m_cs == 5999);
        cs_old   = m_cs;
        run_old  = m_run;
        idle_old = m_idle;
        if (!run_old && c) begin
            m_run = 0; m_idle = 1; m_cs = 0; m_phase = 0; m_lapact = 0;
        end else begin
            if (run_old) begin
                if (tick) begin
                    m_cs    = (m_cs + 1) % 6000;
                    m_phase = 0;
                end else
                    m_phase++;
            end
            if (s) begin
                m_run  = !run_old;
                m_idle = 0;
            end else if (l) begin
                if (run_old && !m_lapact) begin
                    m_lapcs  = cs_old;
                    m_lapact = 1;
                end else if (m_lapact && !idle_old)
                    m_lapact = 0;
            end
        end
        e.fnd  = m_lapact ? to_bcd(m_lapcs) : to_bcd(m_cs);
        e.run  = m_run;
        e.lapa = m_lapact;
        e.wrap = wr;
        exp_q.push_back(e);
    endtask

    // Called between negedge and posedge; returns at negedge+1 with outputs settled.
    task automatic cyc(input bit s, input bit l, input bit c);
        bus.btn_start_stop = s;
        bus.btn_lap        = l;
        bus.btn_clear      = c;
        @(posedge clk);
        model_step(s, l, c);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (mon_en && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk16("sb_fnd_value", bus.fnd_value, e.fnd);
            chk1("sb_running", bus.running, e.run);
            chk1("sb_lap_active", bus.lap_active, e.lapa);
            chk1("sb_wrap", bus.wrap, e.wrap);
        end
    end

    initial begin
        reset_n            = 1'b0;
        bus.btn_start_stop = 1'b0;
        bus.btn_lap        = 1'b0;
        bus.btn_clear      = 1'b0;
        model_reset();
        #1;
        chk16("rst_fnd", bus.fnd_value, 16'h0000);
        chk1("rst_running", bus.running, 1'b0);
        chk1("rst_lap", bus.lap_active, 1'b0);
        chk1("rst_wrap", bus.wrap, 1'b0);
        @(negedge clk);
        #1;
        reset_n = 1'b1;

        // Run to 00.07, then reset asynchronously between edges.
        cyc(1, 0, 0);
        idle(28);
        chk16("pre_rst_0007", bus.fnd_value, 16'h0007);
        #1;
        reset_n = 1'b0;
        #1;
        chk16("async_rst_fnd", bus.fnd_value, 16'h0000);
        chk1("async_rst_running", bus.running, 1'b0);
        chk1("async_rst_lap", bus.lap_active, 1'b0);
        chk1("async_rst_wrap", bus.wrap, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1;
        model_reset();
        reset_n = 1'b1;
        idle(100);
        chk16("post_rst_idle_fnd", bus.fnd_value, 16'h0000);
        chk1("post_rst_idle_running", bus.running, 1'b0);

        // Count and pause.
        cyc(1, 0, 0);
        idle(400);
        chk16("count_0100", bus.fnd_value, 16'h0100);
        cyc(1, 0, 0);
        idle(200);
        chk16("pause_hold_0100", bus.fnd_value, 16'h0100);
        chk1("pause_running", bus.running, 1'b0);
        cyc(1, 0, 0);
        idle(4);
        chk16("resume_0101", bus.fnd_value, 16'h0101);

        // Clear in RUN is ignored; stop then clear zeroes.
        cyc(0, 0, 1);
        idle(8);
        chk16("clear_in_run_0103", bus.fnd_value, 16'h0103);
        chk1("clear_in_run_running", bus.running, 1'b1);
        cyc(1, 0, 0);
        chk16("stop_0103", bus.fnd_value, 16'h0103);
        cyc(0, 0, 1);
        chk16("clear_fnd", bus.fnd_value, 16'h0000);
        chk1("clear_running", bus.running, 1'b0);
        chk1("clear_lap", bus.lap_active, 1'b0);

        // Full carry chain and rollover.
        cyc(1, 0, 0);
        idle(23999);
        chk16("pre_wrap_5999", bus.fnd_value, 16'h5999);
        chk1("pre_wrap_flag", bus.wrap, 1'b0);
        idle(1);
        chk16("wrap_0000", bus.fnd_value, 16'h0000);
        chk1("wrap_flag", bus.wrap, 1'b1);
        chk1("wrap_running", bus.running, 1'b1);
        idle(1);
        chk1("wrap_one_cycle", bus.wrap, 1'b0);
        cyc(1, 0, 0);
        cyc(0, 0, 1);

        // Lap freeze and release.
        cyc(1, 0, 0);
        idle(100);
        cyc(0, 1, 0);
        idle(40);
        chk16("lap_frozen_0025", bus.fnd_value, 16'h0025);
        chk1("lap_active_set", bus.lap_active, 1'b1);
        cyc(0, 1, 0);
        chk16("lap_release_0035", bus.fnd_value, 16'h0035);
        chk1("lap_active_clr", bus.lap_active, 1'b0);

        // Start_stop + lap in RUN: pause, lap dropped.
        cyc(1, 1, 0);
        chk1("stop_lap_running", bus.running, 1'b0);
        chk1("stop_lap_lapa", bus.lap_active, 1'b0);
        chk16("stop_lap_fnd", bus.fnd_value, 16'h0035);

        // Clear + start_stop in PAUSE: back to IDLE.
        cyc(1, 0, 1);
        chk1("clr_start_running", bus.running, 1'b0);
        chk16("clr_start_fnd", bus.fnd_value, 16'h0000);

        // Random pulse soup against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0);
        end

        @(negedge clk);
        mon_en = 1'b0;
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d predictions left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/stopwatch_bcd.md
# stopwatch_bcd

Centisecond stopwatch that turns debounced button pulses into a 4-digit packed-BCD time value, SS.cc from 00.00 to 59.99. It sits directly upstream of the 4-digit FND scanner: its `fnd_value` output drives the scanner's `fnd_value` input unchanged. Its three command inputs come from the `btn_pedge` outputs of three button controllers. The block contains a run/pause/idle state machine, a prescaler, a cascaded BCD counter and a lap-freeze register.

## Interface
- `TICK_DIV`, default 1_000_000: clk cycles per centisecond tick (100 MHz clk). Must be ≥ 2.
- `clk` input 1: system clock. All state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `btn_start_stop` input 1: single-cycle pulse that toggles run/pause.
- `btn_lap` input 1: single-cycle pulse that toggles the lap freeze.
- `btn_clear` input 1: single-cycle pulse that zeroes the stopwatch when it is not running.
- `fnd_value` output 16: packed BCD.
  - [15:12] seconds tens (0–5)
  - [11:8] seconds ones
  - [7:4] centiseconds tens
  - [3:0] centiseconds ones
- `running` output 1: high while in RUN.
- `lap_active` output 1: high while the display is frozen.
- `wrap` output 1: one-cycle pulse on rollover from 59.99 to 00.00.

## Operation
- **Reset**, while `reset_n` = 0 and with no clock needed:
  - state is IDLE; prescaler, BCD digits and lap register are 0.
  - `fnd_value` = 16'h0000; `running`, `lap_active`, `wrap` = 0.
- **State machine** (IDLE, RUN, PAUSE):
  - IDLE + start_stop → RUN.
  - RUN + start_stop → PAUSE.
  - PAUSE + start_stop → RUN.
  - PAUSE + clear → IDLE, which zeroes the digits, the prescaler and `lap_active`.
  - IDLE + clear: stay in IDLE and re-zero.
  - RUN + clear: ignored.
- **Prescaler**:
  - Counts 0..TICK_DIV-1, and only in RUN.
  - At TICK_DIV-1 it returns to 0 and issues an internal tick.
  - It holds its value through PAUSE, so no partial tick is lost, and is cleared only by clear or reset.
- **BCD cascade**:
  - On each tick the cs ones digit increments.
  - 9→0 carries into cs tens; cs tens 9→0 carries into seconds ones; seconds ones 9→0 carries into seconds tens.
  - Seconds tens 5→0 completes the rollover: 59.99 → 00.00, `wrap` pulses for that cycle, and the block stays in RUN.
  - No digit ever holds a non-BCD value.
- **Lap**:
  - In RUN with `lap_active` = 0, a lap pulse copies the current live value (the value before that edge's increment) into the lap register and sets `lap_active`.
  - With `lap_active` = 1, a lap pulse in RUN or PAUSE clears `lap_active`.
  - A lap pulse in IDLE, or in PAUSE with `lap_active` = 0, is ignored.
  - Counting continues while the display is frozen.
- **Display**: `fnd_value` shows the lap register when `lap_active` = 1, otherwise the live digits. It is a register-only mux with no combinational path from the inputs.
- **Simultaneous pulses**, priority clear > start_stop > lap:
  - PAUSE, clear + start_stop: go to IDLE; start is dropped.
  - RUN, start_stop + lap: go to PAUSE; lap is ignored.
  - RUN, clear + anything: clear is ignored and the other pulse is handled normally.
- **Reset mid-operation**: immediately returns every output to its reset value. No tick, wrap or lap capture is emitted on release.

## Timing
- A start pulse sampled at edge k makes `running` = 1 after edge k.
- The first cs increment is visible after edge k+TICK_DIV. After that, one increment every TICK_DIV cycles.
- A stop pulse at edge p gives `running` = 0 after edge p.
  - If a tick coincides with edge p, that tick is applied.
  - No increment occurs after edge p.
- `fnd_value`, `wrap` and `lap_active` update on the same edge as the causing event, i.e. 1-cycle latency from the input pulse.
- `wrap` is high exactly one cycle per rollover.
- A lap capture at edge q holds `fnd_value` constant from after q until the releasing pulse. On release, the live value is visible after that edge.

## Test plan
Bench uses TICK_DIV = 4.
- **Reset**: run to 00.07, then drop `reset_n` between clock edges → all outputs 0 before the next clk edge. Release, and with no pulses for 100 cycles → `fnd_value` stays 16'h0000 and `running` = 0.
- **Count and pause**: start, then 400 cycles → `fnd_value` = 16'h0100. Stop, wait 200 cycles → still 16'h0100. Start again, +4 cycles → 16'h0101.
- **Carry and wrap**: start and run 6000 ticks → 16'h5999 immediately before the rollover edge, then 16'h0000 after it. `wrap` = 1 for exactly one cycle and `running` stays 1.
- **Lap**: start; lap at 00.25 → display 16'h0025 for the next 40 cycles. Lap again → display equals the live value 16'h0035.
- **Clear rules**:
  - Clear in RUN → ignored, counting continues.
  - Stop, then clear → 16'h0000, IDLE, `lap_active` = 0.
  - Clear + start_stop in the same cycle in PAUSE → IDLE, `running` = 0.
- **Coincident stop and lap**: start_stop + lap in the same cycle in RUN → PAUSE, `lap_active` unchanged at 0, and `fnd_value` shows the live value.
